alu_seq16: RTL and testbench
============================

ALU_SEQ16 -- requirements
Module: alu_seq16

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the byte width of the ALU datapath.
REQ-002 SHALL have parameter OPCODE_WIDTH, default 3, meaning the width of the ALU control code.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_start, input, 1 bit: request strobe; sampled only when not busy.
REQ-006 SHALL have port i_op, input, 3 bits: 000 ADD16, 001 INC16, 010 DEC16, 011 ADDSP, 1xx reserved.
REQ-007 SHALL have port i_opa, input, 16 bits: HL, rr or SP operand.
REQ-008 SHALL have port i_opb, input, 16 bits: rr for ADD16; bits[7:0] hold signed e8 for ADDSP.
REQ-009 SHALL have port i_flags, input, 8 bits: current F register (Z=7, N=6, H=5, C=4).
REQ-010 SHALL have ports o_alu_a, o_alu_b, output, DATA_WIDTH bits each: byte operands to the ALU.
REQ-011 SHALL have ports o_alu_op, output, OPCODE_WIDTH bits, and o_alu_cin, output, 1 bit: ALU control code and carry-in.
REQ-012 SHALL have ports i_alu_data and i_alu_flags, input, DATA_WIDTH bits each: combinational ALU result and flags.
REQ-013 SHALL have port o_busy, output, 1 bit: high while a pass is in progress.
REQ-014 SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port o_result, output, 16 bits, and o_flags, output, 8 bits: registered result and merged F.

Function
REQ-016 SHALL implement FSM IDLE, LOW, HIGH, DONE; IDLE->LOW on i_start; LOW->HIGH; HIGH->DONE; DONE->LOW if i_start, else IDLE.
REQ-017 SHALL latch i_op, i_opa, i_opb and i_flags on the accepting edge; later input changes have no effect on the operation.
REQ-018 SHALL assert o_busy in LOW and HIGH only; i_start in LOW or HIGH is ignored.
REQ-019 SHALL have latency 3: start sampled at edge N, o_done high in the cycle after edge N+3, for exactly one cycle.
REQ-020 LOW pass: ADD16 ADD(a.lo,b.lo); INC16 ADD(a.lo,0x01); DEC16 SUB(a.lo,0x01); ADDSP ADD(a.lo,e8); o_alu_cin=0.
REQ-021 HIGH pass: ADD16 ADC(a.hi,b.hi); INC16 ADC(a.hi,0x00); DEC16 SBC(a.hi,0x00); ADDSP ADC(a.hi, e8[7] ? 0xFF : 0x00); o_alu_cin = C captured in LOW.
REQ-022 SHALL register the low byte at the end of LOW and the high byte at the end of HIGH; o_result updates only on entry to DONE.
REQ-023 ADD16 flags: Z = latched Z, N=0, H and C from HIGH-pass ALU flags.
REQ-024 ADDSP flags: Z=0, N=0, H and C from LOW-pass ALU flags.
REQ-025 INC16/DEC16 flags: o_flags = latched i_flags unchanged.
REQ-026 SHALL force o_flags[3:0]=0 in all cases.
REQ-027 Reserved op: IDLE->DONE directly; o_result=i_opa, o_flags=i_flags with [3:0] cleared; o_busy stays 0.
REQ-028 SHALL drive o_alu_a, o_alu_b, o_alu_op, o_alu_cin to 0 in IDLE and DONE.
REQ-029 SHALL wrap silently on 16-bit overflow/underflow (0xFFFF+1 -> 0x0000; 0x0000-1 -> 0xFFFF).

Reset
REQ-030 On i_rst: state=IDLE, o_busy=0, o_done=0, o_result=0x0000, o_flags=0x00, all ALU outputs 0.
REQ-031 Reset in any state SHALL abort the operation with no o_done pulse; reset SHALL take priority over i_start.

Structure
REQ-032 Shared package SHALL hold the i_op encodings, ALU codes (ADD=0, ADC=1, SUB=2, SBC=3), flag bit positions and state encodings.
REQ-033 SHALL be a single module instantiating no sub-modules; the ALU sits outside, in the parent, and connects to the o_alu_*/i_alu_* ports.

Verification
REQ-034 ADD16 opa=0x0FFF, opb=0x0001, flags=0x80 -> o_result=0x1000, o_flags=0xA0, o_done 3 cycles after start.
REQ-035 ADD16 opa=0xFFFF, opb=0x0001, flags=0x00 -> o_result=0x0000, o_flags=0x30.
REQ-036 INC16 0x00FF with flags=0xF0 -> 0x0100, o_flags=0xF0; DEC16 0x0000 with flags=0x50 -> 0xFFFF, o_flags=0x50.
REQ-037 ADDSP opa=0xFFF8, e8=0x08, flags=0x80 -> o_result=0x0000, o_flags=0x30.
REQ-038 i_start held through LOW/HIGH -> ignored; start in DONE -> back-to-back op, o_done again 3 cycles later.
REQ-039 i_rst asserted in HIGH -> no o_done; all outputs at reset values after the next edge; reserved op 3'b101 -> o_done after 1 cycle, o_result=i_opa.

Source files
------------

// File: rtl/alu_seq16_pkg.sv
// Shared encodings for the 16-bit ALU sequencer: request opcodes, byte-ALU
// control codes, F-register bit positions and FSM states.
package alu_seq16_pkg;

    localparam logic [2:0] OP_ADD16 = 3'b000;
    localparam logic [2:0] OP_INC16 = 3'b001;
    localparam logic [2:0] OP_DEC16 = 3'b010;
    localparam logic [2:0] OP_ADDSP = 3'b011;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_ADC = 2'd1,
        ALU_SUB = 2'd2,
        ALU_SBC = 2'd3
    } alu_code_e;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    localparam logic [7:0] MASK_Z    = 8'(1 << FLAG_Z);
    localparam logic [7:0] MASK_HC   = 8'((1 << FLAG_H) | (1 << FLAG_C));
    localparam logic [7:0] MASK_ZNHC = MASK_Z | 8'(1 << FLAG_N) | MASK_HC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Codes 1xx carry no arithmetic and bypass the byte passes.
    function automatic logic op_reserved(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/alu_seq16_if.sv
// Byte-ALU bus between the sequencer (master) and the external ALU (slave)
// that lives in the parent.
interface alu_seq16_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 3
);
    logic [DATA_WIDTH-1:0]   alu_a;
    logic [DATA_WIDTH-1:0]   alu_b;
    logic [OPCODE_WIDTH-1:0] alu_op;
    logic                    alu_cin;
    logic [DATA_WIDTH-1:0]   alu_data;
    logic [DATA_WIDTH-1:0]   alu_flags;

    modport master (
        output alu_a, alu_b, alu_op, alu_cin,
        input  alu_data, alu_flags
    );

    modport slave (
        input  alu_a, alu_b, alu_op, alu_cin,
        output alu_data, alu_flags
    );
endinterface

// File: rtl/alu_seq16.sv
// 16-bit ADD16/INC16/DEC16/ADDSP sequencer: runs two byte passes through an
// external 8-bit ALU and merges the resulting flags into F.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for i_start; ALU outputs parked at zero
// LOW     | low-byte pass on the ALU; low byte and its flags captured
// HIGH    | high-byte pass with carry from LOW; result/flags written
// DONE    | result valid; o_done follows next cycle; may accept a new start
module alu_seq16
    import alu_seq16_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [2:0]              i_op,
    input  logic [15:0]             i_opa,
    input  logic [15:0]             i_opb,
    input  logic [7:0]              i_flags,
    output logic [DATA_WIDTH-1:0]   o_alu_a,
    output logic [DATA_WIDTH-1:0]   o_alu_b,
    output logic [OPCODE_WIDTH-1:0] o_alu_op,
    output logic                    o_alu_cin,
    input  logic [DATA_WIDTH-1:0]   i_alu_data,
    input  logic [DATA_WIDTH-1:0]   i_alu_flags,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [15:0]             o_result,
    output logic [7:0]              o_flags
);

    state_e     state;
    state_e     state_nxt;
    logic       accept;

    logic [2:0]  op_q;
    logic [15:0] opa_q;
    logic [15:0] opb_q;
    logic [7:0]  flags_q;
    logic [7:0]  lo_data_q;
    logic [7:0]  lo_flags_q;

    logic [7:0]  alu_data8;
    logic [7:0]  alu_flags8;
    logic [7:0]  alu_a8;
    logic [7:0]  alu_b8;
    alu_code_e   alu_code;
    logic        alu_cin;
    logic [7:0]  flags_merged;

    assign alu_data8  = i_alu_data[7:0];
    assign alu_flags8 = i_alu_flags[7:0];
    assign accept     = i_start && (state == ST_IDLE || state == ST_DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = op_reserved(i_op) ? ST_DONE : ST_LOW;
                end
            end
            ST_LOW:  state_nxt = ST_HIGH;
            ST_HIGH: state_nxt = ST_DONE;
            ST_DONE: begin
                if (i_start) begin
                    state_nxt = op_reserved(i_op) ? ST_DONE : ST_LOW;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_a8   = 8'h00;
        alu_b8   = 8'h00;
        alu_code = ALU_ADD;
        alu_cin  = 1'b0;
        if (state == ST_LOW) begin
            alu_a8 = opa_q[7:0];
            case (op_q)
                OP_ADD16: alu_b8 = opb_q[7:0];
                OP_INC16: alu_b8 = 8'h01;
                OP_DEC16: begin
                    alu_b8   = 8'h01;
                    alu_code = ALU_SUB;
                end
                OP_ADDSP: alu_b8 = opb_q[7:0];
                default:  alu_a8 = 8'h00;
            endcase
        end else if (state == ST_HIGH) begin
            alu_a8  = opa_q[15:8];
            alu_cin = lo_flags_q[FLAG_C];
            alu_code = ALU_ADC;
            case (op_q)
                OP_ADD16: alu_b8 = opb_q[15:8];
                OP_INC16: alu_b8 = 8'h00;
                OP_DEC16: alu_code = ALU_SBC;
                // sign-extend e8 into the high byte
                OP_ADDSP: alu_b8 = {8{opb_q[7]}};
                default: begin
                    alu_a8   = 8'h00;
                    alu_cin  = 1'b0;
                    alu_code = ALU_ADD;
                end
            endcase
        end
    end

    always_comb begin
        flags_merged = flags_q & MASK_ZNHC;
        case (op_q)
            OP_ADD16: flags_merged = (flags_q & MASK_Z) | (alu_flags8 & MASK_HC);
            OP_ADDSP: flags_merged = lo_flags_q & MASK_HC;
            default:  flags_merged = flags_q & MASK_ZNHC;
        endcase
    end

    assign o_alu_a   = DATA_WIDTH'(alu_a8);
    assign o_alu_b   = DATA_WIDTH'(alu_b8);
    assign o_alu_op  = OPCODE_WIDTH'(alu_code);
    assign o_alu_cin = alu_cin;
    assign o_busy    = (state == ST_LOW) || (state == ST_HIGH);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_done     <= 1'b0;
            o_result   <= 16'h0000;
            o_flags    <= 8'h00;
            op_q       <= 3'b000;
            opa_q      <= 16'h0000;
            opb_q      <= 16'h0000;
            flags_q    <= 8'h00;
            lo_data_q  <= 8'h00;
            lo_flags_q <= 8'h00;
        end else begin
            o_done <= (state == ST_DONE);
            if (accept) begin
                op_q    <= i_op;
                opa_q   <= i_opa;
                opb_q   <= i_opb;
                flags_q <= i_flags;
                if (op_reserved(i_op)) begin
                    o_result <= i_opa;
                    o_flags  <= i_flags & MASK_ZNHC;
                end
            end
            if (state == ST_LOW) begin
                lo_data_q  <= alu_data8;
                lo_flags_q <= alu_flags8;
            end
            if (state == ST_HIGH) begin
                o_result <= {alu_data8, lo_data_q};
                o_flags  <= flags_merged;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq16.sv
// Directed bench for alu_seq16 with a behavioural 8-bit ALU on the bus.
module tb_alu_seq16;
    import alu_seq16_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [2:0]  i_op;
    logic [15:0] i_opa;
    logic [15:0] i_opb;
    logic [7:0]  i_flags;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_result;
    logic [7:0]  o_flags;

    int errors = 0;
    int checks = 0;

    alu_seq16_if #(.DATA_WIDTH(8), .OPCODE_WIDTH(3)) alu_bus ();

    alu_seq16 #(.DATA_WIDTH(8), .OPCODE_WIDTH(3)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_op        (i_op),
        .i_opa       (i_opa),
        .i_opb       (i_opb),
        .i_flags     (i_flags),
        .o_alu_a     (alu_bus.alu_a),
        .o_alu_b     (alu_bus.alu_b),
        .o_alu_op    (alu_bus.alu_op),
        .o_alu_cin   (alu_bus.alu_cin),
        .i_alu_data  (alu_bus.alu_data),
        .i_alu_flags (alu_bus.alu_flags),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_result    (o_result),
        .o_flags     (o_flags)
    );

    // Reference byte ALU: H is the nibble carry/borrow, C the byte carry/borrow.
    logic [8:0] sum9;
    logic [4:0] half5;
    always_comb begin
        sum9  = 9'h000;
        half5 = 5'h00;
        case (alu_bus.alu_op)
            3'd0: begin
                sum9  = {1'b0, alu_bus.alu_a} + {1'b0, alu_bus.alu_b};
                half5 = {1'b0, alu_bus.alu_a[3:0]} + {1'b0, alu_bus.alu_b[3:0]};
            end
            3'd1: begin
                sum9  = {1'b0, alu_bus.alu_a} + {1'b0, alu_bus.alu_b} + {8'h00, alu_bus.alu_cin};
                half5 = {1'b0, alu_bus.alu_a[3:0]} + {1'b0, alu_bus.alu_b[3:0]} + {4'h0, alu_bus.alu_cin};
            end
            3'd2: begin
                sum9  = {1'b0, alu_bus.alu_a} - {1'b0, alu_bus.alu_b};
                half5 = {1'b0, alu_bus.alu_a[3:0]} - {1'b0, alu_bus.alu_b[3:0]};
            end
            3'd3: begin
                sum9  = {1'b0, alu_bus.alu_a} - {1'b0, alu_bus.alu_b} - {8'h00, alu_bus.alu_cin};
                half5 = {1'b0, alu_bus.alu_a[3:0]} - {1'b0, alu_bus.alu_b[3:0]} - {4'h0, alu_bus.alu_cin};
            end
            default: sum9 = 9'h000;
        endcase
        alu_bus.alu_data  = sum9[7:0];
        alu_bus.alu_flags = {(sum9[7:0] == 8'h00), alu_bus.alu_op[1], half5[4], sum9[8], 4'h0};
    end

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One request; inputs are scrambled right after acceptance to prove latching.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [15:0] a, input logic [15:0] b, input logic [7:0] f,
                          input logic [15:0] exp_res, input logic [7:0] exp_f,
                          input int exp_lat, input logic [2:0] lo_op, input logic [2:0] hi_op);
        int k;
        @(negedge i_clk);
        i_op = op; i_opa = a; i_opb = b; i_flags = f; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0; i_opa = ~a; i_opb = ~b; i_flags = ~f; i_op = op ^ 3'b001;
        k = 0;
        check({name, "_busy"}, 32'(o_busy), 32'(exp_lat == 3));
        if (exp_lat == 3) begin
            check({name, "_lo_aluop"}, 32'(alu_bus.alu_op), 32'(lo_op));
            check({name, "_lo_alua"}, 32'(alu_bus.alu_a), 32'(a[7:0]));
            @(negedge i_clk);
            k = 1;
            check({name, "_hi_aluop"}, 32'(alu_bus.alu_op), 32'(hi_op));
            check({name, "_hi_alua"}, 32'(alu_bus.alu_a), 32'(a[15:8]));
        end
        while (!o_done && k < 8) begin
            @(negedge i_clk);
            k++;
        end
        check({name, "_latency"}, 32'(k), 32'(exp_lat));
        check({name, "_result"}, 32'(o_result), 32'(exp_res));
        check({name, "_flags"}, 32'(o_flags), 32'(exp_f));
        @(negedge i_clk);
        check({name, "_done_pulse"}, 32'(o_done), 32'(0));
        i_op = 3'b000; i_opa = 16'h0000; i_opb = 16'h0000; i_flags = 8'h00;
    endtask

    initial begin
        int k;
        int seen;
        i_rst = 1'b1; i_start = 1'b0; i_op = 3'b000;
        i_opa = 16'h0000; i_opb = 16'h0000; i_flags = 8'h00;
        repeat (3) @(negedge i_clk);
        check("rst_busy", 32'(o_busy), 32'(0));
        check("rst_done", 32'(o_done), 32'(0));
        check("rst_result", 32'(o_result), 32'(0));
        check("rst_flags", 32'(o_flags), 32'(0));
        check("rst_alu", {alu_bus.alu_a, alu_bus.alu_b, 5'(alu_bus.alu_op), alu_bus.alu_cin, 2'b00}, 32'(0));
        i_rst = 1'b0;

        run_op("add_halfcarry", 3'b000, 16'h0FFF, 16'h0001, 8'h80, 16'h1000, 8'hA0, 3, 3'd0, 3'd1);
        run_op("add_wrap",      3'b000, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h30, 3, 3'd0, 3'd1);
        run_op("add_plain",     3'b000, 16'h1234, 16'h4321, 8'hC0, 16'h5555, 8'h80, 3, 3'd0, 3'd1);
        run_op("inc",           3'b001, 16'h00FF, 16'h0000, 8'hF0, 16'h0100, 8'hF0, 3, 3'd0, 3'd1);
        run_op("dec_wrap",      3'b010, 16'h0000, 16'h0000, 8'h5F, 16'hFFFF, 8'h50, 3, 3'd2, 3'd3);
        run_op("addsp_pos",     3'b011, 16'hFFF8, 16'h0008, 8'h80, 16'h0000, 8'h30, 3, 3'd0, 3'd1);
        run_op("addsp_neg",     3'b011, 16'h1000, 16'h00FF, 8'hF0, 16'h0FFF, 8'h00, 3, 3'd0, 3'd1);
        run_op("reserved",      3'b101, 16'hBEEF, 16'h1111, 8'hFF, 16'hBEEF, 8'hF0, 1, 3'd0, 3'd0);

        // start held high through LOW/HIGH, then a second op accepted from DONE
        @(negedge i_clk);
        i_op = 3'b000; i_opa = 16'h0FFF; i_opb = 16'h0001; i_flags = 8'h80; i_start = 1'b1;
        @(negedge i_clk);
        check("b2b_busy_low", 32'(o_busy), 32'(1));
        i_op = 3'b001; i_opa = 16'h00FF; i_opb = 16'h0000; i_flags = 8'hF0;
        @(negedge i_clk);
        check("b2b_busy_high", 32'(o_busy), 32'(1));
        @(negedge i_clk);
        check("b2b_done_state_busy", 32'(o_busy), 32'(0));
        check("b2b_first_result", 32'(o_result), 32'(16'h1000));
        check("b2b_first_flags", 32'(o_flags), 32'(8'hA0));
        @(negedge i_clk);
        check("b2b_first_done", 32'(o_done), 32'(1));
        check("b2b_second_busy", 32'(o_busy), 32'(1));
        i_start = 1'b0;
        k = 0;
        do begin
            @(negedge i_clk);
            k++;
        end while (!o_done && k < 8);
        check("b2b_second_latency", 32'(k), 32'(3));
        check("b2b_second_result", 32'(o_result), 32'(16'h0100));
        check("b2b_second_flags", 32'(o_flags), 32'(8'hF0));
        @(negedge i_clk);

        // reset during HIGH aborts the operation
        i_op = 3'b000; i_opa = 16'h1234; i_opb = 16'h4321; i_flags = 8'hC0; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        check("abort_in_high", 32'(o_busy), 32'(1));
        i_rst = 1'b1;
        @(negedge i_clk);
        check("abort_done", 32'(o_done), 32'(0));
        check("abort_busy", 32'(o_busy), 32'(0));
        check("abort_result", 32'(o_result), 32'(0));
        check("abort_flags", 32'(o_flags), 32'(0));
        check("abort_alu", {alu_bus.alu_a, alu_bus.alu_b, 5'(alu_bus.alu_op), alu_bus.alu_cin, 2'b00}, 32'(0));
        i_rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge i_clk);
            if (o_done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
